// File: rtl/mul_pkg.sv
// Shared defaults, derived widths and controller state encoding for the
// multiplier operand-issue / result-capture stage.
package mul_pkg;

    localparam int N_DEF       = 8;
    localparam int PROD_W_DEF  = 2 * N_DEF;
    localparam int DEPTH_DEF   = 4;
    localparam int PTR_W_DEF   = $clog2(DEPTH_DEF);
    localparam int TIMEOUT_DEF = N_DEF + 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/mul_op_fifo.sv
// Small operand-pair FIFO; pointers wrap naturally because DEPTH is a power of 2.
module mul_op_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Storage is pure data: no reset, written only on an accepted push.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issues buffered operand pairs to a sibling shift-add multiplier and captures
// each product into a one-entry valid/ready output register, with a watchdog.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int PTR_W   = PTR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_mlier,
    input  logic [N-1:0]     in_mcand,
    output logic             mul_start,
    output logic [N-1:0]     mul_mlier,
    output logic [N-1:0]     mul_mcand,
    input  logic             mul_valid,
    input  logic [2*N:0]     mul_prodt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_prod,
    output logic             busy,
    output logic             err_timeout,
    output logic             err_ovf
);

    localparam int              TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t              state, state_nxt;
    logic [TMR_W-1:0]    timer;
    logic                push, pop, capture, abort, slot_free;
    logic                fifo_full, fifo_empty;
    logic [PTR_W:0]      fifo_count;
    logic [2*N-1:0]      head;

    assign push      = in_valid && in_ready;
    assign in_ready  = !fifo_full;
    assign slot_free = !out_valid || out_ready;
    assign busy      = (state != IDLE) || (fifo_count != '0);

    mul_op_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .W     (2 * N)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({in_mlier, in_mcand}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // A finished product waiting on a full slot keeps the job parked.
                if (mul_valid) begin
                    if (slot_free) begin
                        capture   = 1'b1;
                        state_nxt = GAP;
                    end
                end else if (timer == TMR_LAST) begin
                    abort     = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            timer       <= '0;
            mul_start   <= 1'b0;
            mul_mlier   <= '0;
            mul_mcand   <= '0;
            out_valid   <= 1'b0;
            out_prod    <= '0;
            err_timeout <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            state <= state_nxt;

            if (pop) begin
                mul_mlier <= head[2*N-1:N];
                mul_mcand <= head[N-1:0];
                mul_start <= 1'b1;
                timer     <= '0;
            end else if (capture || abort) begin
                mul_start <= 1'b0;
            end

            // Watchdog freezes while a completed product waits for the slot.
            if (state == RUN && !(mul_valid && !slot_free))
                timer <= timer + 1'b1;

            if (capture) begin
                out_prod  <= mul_prodt[2*N-1:0];
                out_valid <= 1'b1;
                err_ovf   <= err_ovf | mul_prodt[2*N];
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (abort) err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural stand-in for the multiplier.
module tb_mul_issue_ctrl;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_mlier;
    logic [7:0]  in_mcand;
    logic        mul_start;
    logic [7:0]  mul_mlier;
    logic [7:0]  mul_mcand;
    logic        mul_valid;
    logic [16:0] mul_prodt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_prod;
    logic        busy;
    logic        err_timeout;
    logic        err_ovf;

    logic        stub_hang;
    logic        stub_ovf;
    logic [3:0]  stub_cnt;

    int tests = 0;
    int fails = 0;

    mul_issue_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mlier    (in_mlier),
        .in_mcand    (in_mcand),
        .mul_start   (mul_start),
        .mul_mlier   (mul_mlier),
        .mul_mcand   (mul_mcand),
        .mul_valid   (mul_valid),
        .mul_prodt   (mul_prodt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_prod    (out_prod),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_ovf     (err_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Multiplier stand-in: valid appears N+1 edges after start rises, held while start stays high.
    always @(posedge clock) begin
        if (!reset || !mul_start) begin
            stub_cnt  <= 4'd0;
            mul_valid <= 1'b0;
            mul_prodt <= '0;
        end else if (stub_cnt == 4'd8) begin
            if (!stub_hang) begin
                mul_valid <= 1'b1;
                mul_prodt <= {stub_ovf, 16'(mul_mlier) * 16'(mul_mcand)};
            end
        end else begin
            stub_cnt <= stub_cnt + 4'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // One job from an idle controller; lat = edges from accept to out_valid (0 if none within bound).
    task automatic run_job(input logic [7:0] a, input logic [7:0] b,
                           output logic [15:0] prod, output int lat);
        in_mlier = a;
        in_mcand = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat  = 0;
        prod = '0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (out_valid) begin
                lat  = i;
                prod = out_prod;
                break;
            end
        end
    endtask

    logic [15:0] prod;
    int          lat;
    int          acc;
    int          nres;
    int          nout;
    logic [15:0] res [8];

    logic [7:0]  ca   [4] = '{8'd0, 8'd255, 8'd255, 8'd1};
    logic [7:0]  cb   [4] = '{8'd0, 8'd255, 8'd1,   8'd0};
    logic [15:0] cexp [4] = '{16'd0, 16'd65025, 16'd255, 16'd0};

    logic [7:0]  fa   [6] = '{8'd3, 8'd7, 8'd12, 8'd200, 8'd100, 8'd50};
    logic [7:0]  fb   [6] = '{8'd5, 8'd9, 8'd12, 8'd2,   8'd100, 8'd50};
    logic [15:0] fexp [5] = '{16'd15, 16'd63, 16'd144, 16'd400, 16'd10000};

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_mlier  = '0;
        in_mcand  = '0;
        out_ready = 1'b1;
        stub_hang = 1'b0;
        stub_ovf  = 1'b0;
        idle(2);

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_busy", busy, 0);
        check("rst_err_to", err_timeout, 0);
        check("rst_err_ovf", err_ovf, 0);
        reset = 1'b1;
        idle(1);

        // Single job: latency, product, start drop and return to idle.
        run_job(8'd13, 8'd11, prod, lat);
        check("single_lat", lat, 11);
        check("single_prod", prod, 143);
        check("single_start_drop", mul_start, 0);
        check("single_gap_busy", busy, 1);
        tick();
        check("single_drained", out_valid, 0);
        check("single_start_gap", mul_start, 0);
        tick();
        check("single_idle", busy, 0);

        for (int k = 0; k < 4; k++) begin
            run_job(ca[k], cb[k], prod, lat);
            check($sformatf("corner%0d_prod", k), prod, cexp[k]);
            check($sformatf("corner%0d_lat", k), lat, 11);
            check($sformatf("corner%0d_ovf", k), err_ovf, 0);
            idle(2);
        end

        // Fill with the output blocked: five accepted, the sixth refused.
        out_ready = 1'b0;
        acc       = 0;
        in_valid  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_mlier = fa[k];
            in_mcand = fb[k];
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        check("fill_accepted", acc, 5);
        check("fill_in_ready", in_ready, 0);
        for (int i = 0; i < 40 && !out_valid; i++) tick();
        check("hold_first_valid", out_valid, 1);
        idle(20);
        check("hold_valid", out_valid, 1);
        check("hold_prod", out_prod, 15);
        check("hold_start", mul_start, 1);
        check("hold_no_timeout", err_timeout, 0);

        out_ready = 1'b1;
        nres      = 0;
        for (int i = 0; i < 120; i++) begin
            if (out_valid) begin
                if (nres < 8) res[nres] = out_prod;
                nres++;
            end
            tick();
        end
        check("drain_count", nres, 5);
        for (int k = 0; k < 5; k++)
            check($sformatf("drain%0d_prod", k), res[k], fexp[k]);
        check("drain_idle", busy, 0);
        check("drain_in_ready", in_ready, 1);

        // Watchdog: stand-in never answers.
        stub_hang = 1'b1;
        in_mlier  = 8'd9;
        in_mcand  = 8'd9;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        idle(12);
        check("to_before", err_timeout, 0);
        tick();
        check("to_flag", err_timeout, 1);
        check("to_no_output", out_valid, 0);
        check("to_start_drop", mul_start, 0);
        tick();
        check("to_idle", busy, 0);
        stub_hang = 1'b0;
        run_job(8'd6, 8'd7, prod, lat);
        check("to_next_prod", prod, 42);
        check("to_next_lat", lat, 11);
        check("to_sticky", err_timeout, 1);
        idle(2);

        // Product bit 2N set.
        stub_ovf = 1'b1;
        run_job(8'd2, 8'd3, prod, lat);
        check("ovf_prod", prod, 6);
        check("ovf_flag", err_ovf, 1);
        stub_ovf = 1'b0;
        idle(2);

        // Reset mid-run with two pairs still queued.
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_mlier = fa[k];
            in_mcand = fb[k];
            tick();
        end
        in_valid = 1'b0;
        idle(3);
        check("mid_running", mul_start, 1);
        reset = 1'b0;
        tick();
        check("mid_rst_start", mul_start, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err_to", err_timeout, 0);
        check("mid_rst_err_ovf", err_ovf, 0);
        reset = 1'b1;
        nout  = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid || mul_start) nout++;
        end
        check("mid_no_activity", nout, 0);
        run_job(8'd4, 8'd5, prod, lat);
        check("mid_recover_prod", prod, 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
